// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_TERR
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the arbiter: requesting masters on m_*, the shared slave on s_*.
// slave = the arbiter's view; master = the masters and slave device around it.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = WB_DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]     m_sel_i;
  logic [WB_DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;

  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [WB_ADDR_WIDTH-1:0]             s_adr_o;
  logic [WB_DATA_WIDTH-1:0]             s_dat_o;
  logic [SEL_WIDTH-1:0]                 s_sel_o;
  logic [WB_DATA_WIDTH-1:0]             s_dat_i;
  logic                                 s_ack_i;
  logic                                 s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Rotating-priority picker: first request found scanning upward from last_i+1, with wrap.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(last_i) + k) % N;
      if (!valid_o && req_i[pos]) begin
        valid_o    = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 classic arbiter: round-robin grant held for the
// whole bus cycle, with a per-transfer watchdog that errors out stalled slaves.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                   clk,
  input  logic                   rst_i,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   busy_o
);

  localparam int unsigned IW  = idx_width(NUM_MASTERS);
  localparam int unsigned SW  = WB_DATA_WIDTH / 8;
  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The transition is taken on the stalled cycle that brings the count to TIMEOUT.
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          last_q;
  logic [WDW-1:0]         wd_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic        own;
  logic        terr;
  logic        cyc_g;
  logic        stall;
  int unsigned g;

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (bus.m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Reset gates the slave side combinationally so a mid-cycle reset drops it at once.
  always_comb begin
    g           = 32'(last_q);
    own         = (state_q == ARB_OWN) && !rst_i;
    terr        = (state_q == ARB_TERR) && !rst_i;
    cyc_g       = bus.m_cyc_i[g];
    bus.s_cyc_o = own && cyc_g;
    bus.s_stb_o = own && bus.m_stb_i[g];
    bus.s_we_o  = own && bus.m_we_i[g];
    bus.s_adr_o = bus.m_adr_i[g*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    bus.s_dat_o = bus.m_dat_i[g*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    bus.s_sel_o = bus.m_sel_i[g*SW +: SW];
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = gnt_q & {NUM_MASTERS{own && bus.s_ack_i}};
    bus.m_err_o = gnt_q & {NUM_MASTERS{(own && bus.s_err_i) || terr}};
    stall       = bus.s_stb_o && !bus.s_ack_i && !bus.s_err_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          wd_q <= '0;
          if (pick_valid) begin
            state_q <= ARB_OWN;
            gnt_q   <= pick_gnt;
            last_q  <= pick_idx;
          end
        end
        ARB_OWN: begin
          if (!cyc_g) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            wd_q    <= '0;
          end else if ((TIMEOUT > 0) && stall) begin
            if (wd_q == WD_LAST) begin
              state_q <= ARB_TERR;
              wd_q    <= '0;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end else begin
            wd_q <= '0;
          end
        end
        ARB_TERR: begin
          wd_q <= '0;
          if (cyc_g) begin
            state_q <= ARB_OWN;
          end else begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
          wd_q    <= '0;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed stimulus pushes expected grants and
// terminations; a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NM-1:0] gnt_o;
  logic          busy_o;

  logic          ack_man;
  logic          err_man;
  logic          auto_ack;
  logic [DW-1:0] sdat;

  wb_rr_arbiter_if #(
    .NUM_MASTERS   (NM),
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW)
  ) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS   (NM),
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT       (TO)
  ) dut (
    .clk    (clk),
    .rst_i  (rst_i),
    .bus    (bus),
    .gnt_o  (gnt_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  assign bus.s_ack_i = ack_man | (auto_ack & bus.s_cyc_o & bus.s_stb_o);
  assign bus.s_err_i = err_man;
  assign bus.s_dat_i = sdat;

  typedef struct {
    bit            is_gnt;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic          scyc;
    bit            chk_dat;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic void fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      fail(name, act, exp);
    end else begin
      total++;
    end
  endfunction

  function automatic void exp_gnt(input logic [NM-1:0] v);
    ev_t e;
    e = '{is_gnt: 1'b1, ack: v, err: '0, scyc: 1'b0, chk_dat: 1'b0, we: 1'b0,
          adr: '0, dat: '0, sel: '0};
    q.push_back(e);
  endfunction

  function automatic void exp_term(input int k, input bit is_err, input logic scyc,
                                   input bit chk_dat, input logic we,
                                   input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    ev_t e;
    e = '{is_gnt: 1'b0, ack: '0, err: '0, scyc: scyc, chk_dat: chk_dat, we: we,
          adr: adr, dat: dat, sel: SW'(k + 1)};
    if (is_err) e.err[k] = 1'b1;
    else        e.ack[k] = 1'b1;
    q.push_back(e);
  endfunction

  // Monitor: pops one expected event per grant change and per ack/err presentation.
  logic [NM-1:0] prev_gnt = '0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        chk("gnt_onehot0", 64'($onehot0(gnt_o)), 64'(1));
        chk("resp_only_to_granted", 64'((bus.m_ack_o | bus.m_err_o) & ~gnt_o), 64'(0));
        if (gnt_o != prev_gnt && gnt_o != '0) begin
          chk("dead_cycle_before_grant", 64'(prev_gnt), 64'(0));
          if (q.size() == 0) begin
            fail("unexpected_grant", 64'(gnt_o), 64'(0));
          end else begin
            e = q.pop_front();
            if (!e.is_gnt) fail("grant_out_of_order", 64'(gnt_o), 64'(e.ack | e.err));
            else           chk("grant", 64'(gnt_o), 64'(e.ack));
          end
        end
        if ((bus.m_ack_o | bus.m_err_o) != '0) begin
          if (q.size() == 0) begin
            fail("unexpected_term", 64'({bus.m_ack_o, bus.m_err_o}), 64'(0));
          end else begin
            e = q.pop_front();
            if (e.is_gnt) begin
              fail("term_out_of_order", 64'({bus.m_ack_o, bus.m_err_o}), 64'(e.ack));
            end else begin
              chk("term_ack", 64'(bus.m_ack_o), 64'(e.ack));
              chk("term_err", 64'(bus.m_err_o), 64'(e.err));
              chk("term_s_cyc", 64'(bus.s_cyc_o), 64'(e.scyc));
              if (e.chk_dat) begin
                chk("term_adr", 64'(bus.s_adr_o), 64'(e.adr));
                chk("term_sel", 64'(bus.s_sel_o), 64'(e.sel));
                if (e.we) chk("term_wdat", 64'(bus.s_dat_o), 64'(e.dat));
                else      chk("term_rdat", 64'(bus.m_dat_o), 64'(e.dat));
              end
            end
          end
        end
      end
      prev_gnt = gnt_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    bus.m_cyc_i[k]          = cyc;
    bus.m_stb_i[k]          = stb;
    bus.m_we_i[k]           = we;
    bus.m_adr_i[k*AW +: AW] = adr;
    bus.m_dat_i[k*DW +: DW] = dat;
    bus.m_sel_i[k*SW +: SW] = SW'(k + 1);
  endtask

  // Master k keeps stb up until it has seen n terminations, then drops cyc.
  task automatic beat_auto(input int k, input int n, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    int got;
    bit seen;
    got = 0;
    drive(k, 1'b1, 1'b1, we, adr, dat);
    for (int c = 0; c < 60 && got < n; c++) begin
      @(negedge clk);
      seen = bus.m_ack_o[k] | bus.m_err_o[k];
      @(posedge clk);
      #1;
      if (seen) got++;
    end
    drive(k, 1'b0, 1'b0, we, adr, dat);
    chk("beats_completed", 64'(got), 64'(n));
  endtask

  task automatic agent(input int k);
    for (int r = 0; r < 2; r++) begin
      beat_auto(k, 1, 1'b1, 32'h1000_0000 + 32'(k * 4), 32'h100 + 32'(k));
      tick();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL global_time_limit: got timeout want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int stalls;
    rst_i       = 1'b1;
    ack_man     = 1'b0;
    err_man     = 1'b0;
    auto_ack    = 1'b0;
    sdat        = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    chk("rst_ack_err", 64'({bus.m_ack_o, bus.m_err_o}), 64'(0));

    // Single master 2 writes 0xA5 to 0x9000_0004.
    exp_gnt(4'b0100);
    exp_term(2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h9000_0004, 32'h0000_00A5);
    drive(2, 1'b1, 1'b1, 1'b1, 32'h9000_0004, 32'h0000_00A5);
    tick();
    chk("t1_gnt", 64'(gnt_o), 64'(4'b0100));
    chk("t1_s_cyc", 64'(bus.s_cyc_o), 64'(1));
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    drive(2, 1'b0, 1'b0, 1'b1, 32'h9000_0004, 32'h0000_00A5);
    #1;
    chk("t1_busy_on_drop", 64'(busy_o), 64'(1));
    chk("t1_s_cyc_on_drop", 64'(bus.s_cyc_o), 64'(0));
    tick();
    chk("t1_busy_after", 64'(busy_o), 64'(0));
    chk("t1_gnt_after", 64'(gnt_o), 64'(0));

    // Round robin across masters 0,1,3 from a fresh reset.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp_gnt(4'b0001);
      exp_term(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h100);
      exp_gnt(4'b0010);
      exp_term(1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 32'h101);
      exp_gnt(4'b1000);
      exp_term(3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_000C, 32'h103);
    end
    auto_ack = 1'b1;
    fork
      agent(0);
      agent(1);
      agent(3);
    join

    // Master 1 burst of 4 holds the grant against master 0.
    exp_gnt(4'b0010);
    for (int b = 0; b < 4; b++) exp_term(1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000_0010, 32'hB0B0_0001);
    exp_gnt(4'b0001);
    exp_term(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'hB0B0_0000);
    fork
      beat_auto(1, 4, 1'b1, 32'h2000_0010, 32'hB0B0_0001);
      begin
        tick();
        tick();
        beat_auto(0, 1, 1'b1, 32'h2000_0000, 32'hB0B0_0000);
      end
    join
    tick();

    // Watchdog: master 2 read never acked.
    auto_ack = 1'b0;
    exp_gnt(4'b0100);
    exp_term(2, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b1, 1'b1, 1'b0, 32'h3000_0008, '0);
    tick();
    stalls = 0;
    for (int c = 0; c < 40 && bus.m_err_o == '0; c++) begin
      if (bus.s_cyc_o && bus.s_stb_o) stalls++;
      tick();
    end
    chk("t4_stall_cycles", 64'(stalls), 64'(TO));
    chk("t4_terr_err", 64'(bus.m_err_o), 64'(4'b0100));
    chk("t4_terr_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    tick();
    chk("t4_err_one_cycle", 64'(bus.m_err_o), 64'(0));
    chk("t4_back_to_own", 64'(bus.s_cyc_o), 64'(1));
    drive(2, 1'b0, 1'b0, 1'b0, 32'h3000_0008, '0);
    tick();
    chk("t4_idle_busy", 64'(busy_o), 64'(0));
    chk("t4_idle_gnt", 64'(gnt_o), 64'(0));

    // Reset in the middle of a master 3 read.
    exp_gnt(4'b1000);
    drive(3, 1'b1, 1'b1, 1'b0, 32'h4000_000C, '0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_gnt", 64'(gnt_o), 64'(0));
    chk("t5_busy", 64'(busy_o), 64'(0));
    chk("t5_s_ctrl", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'(0));
    chk("t5_ack_err", 64'({bus.m_ack_o, bus.m_err_o}), 64'(0));
    sdat = 32'hDEAD_BEEF;
    exp_gnt(4'b0001);
    exp_term(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'hDEAD_BEEF);
    exp_gnt(4'b1000);
    exp_term(3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4000_000C, 32'hDEAD_BEEF);
    auto_ack = 1'b1;
    fork
      beat_auto(0, 1, 1'b0, 32'h4000_0000, '0);
      beat_auto(3, 1, 1'b0, 32'h4000_000C, '0);
    join
    tick();

    // Slave error on a master 1 read; watchdog must restart from zero after it.
    auto_ack = 1'b0;
    sdat     = 32'h1234_5678;
    exp_gnt(4'b0010);
    exp_term(1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5000_0004, 32'h1234_5678);
    exp_term(1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5000_0004, 32'h1234_5678);
    exp_gnt(4'b0100);
    exp_term(2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5000_0008, 32'hCAFE_0002);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h5000_0004, '0);
    drive(2, 1'b1, 1'b1, 1'b1, 32'h5000_0008, 32'hCAFE_0002);
    tick();
    repeat (4) tick();
    err_man = 1'b1;
    tick();
    err_man = 1'b0;
    repeat (7) tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h5000_0004, '0);
    auto_ack = 1'b1;
    beat_auto(2, 1, 1'b1, 32'h5000_0008, 32'hCAFE_0002);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone B3 classic arbiter with round-robin grant.
- Shares one slave port, e.g. the scratchpad SRAM or the pad bridge, between the CPU data master and both DMA masters. It sits in front of the interconnect slave port.
- The grant is held for the whole bus cycle, including any cyc-locked burst.
- A per-transfer watchdog terminates stalled slaves with an error.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 32, data width. Select width is WB_DATA_WIDTH/8.
- TIMEOUT, 255, cycles an un-acked strobe may wait before error. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_adr_i  in  NUM_MASTERS*WB_ADDR_WIDTH  packed addresses, master k at slice k.
- m_dat_i  in  NUM_MASTERS*WB_DATA_WIDTH  packed write data.
- m_sel_i  in  NUM_MASTERS*WB_DATA_WIDTH/8  packed byte selects.
- m_dat_o  out  WB_DATA_WIDTH  read data broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control.
- s_adr_o  out  WB_ADDR_WIDTH  slave address.
- s_dat_o  out  WB_DATA_WIDTH  slave write data.
- s_sel_o  out  WB_DATA_WIDTH/8  slave byte selects.
- s_dat_i  in  WB_DATA_WIDTH  slave read data.
- s_ack_i, s_err_i  in  1  slave termination.
- gnt_o  out  NUM_MASTERS  one-hot current grant, registered.
- busy_o  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset (rst_i high at a clk edge, including mid-cycle):
  - FSM goes to IDLE; gnt_o=0; last_grant=NUM_MASTERS-1, so master 0 has first priority.
  - Watchdog counter=0.
  - All s_* control outputs, m_ack_o, m_err_o and busy_o are 0. s_adr_o, s_dat_o, s_sel_o and m_dat_o are don't-care.
  - The slave cycle is dropped immediately; no ack reaches any master.
- IDLE:
  - If any m_cyc_i bit is high, the winner is the first requester scanning upward from last_grant+1 with wrap-around modulo NUM_MASTERS.
  - The winner is registered into gnt_o and last_grant at the next edge; state goes to OWN.
  - Latency is 1 cycle from cyc to s_cyc_o.
  - s_cyc_o=0 in IDLE.
- OWN:
  - s_cyc_o = m_cyc_i[g]; s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are combinationally muxed from granted master g.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; all other m_ack_o and m_err_o bits are 0. m_dat_o=s_dat_i.
  - When m_cyc_i[g] is low: s_cyc_o=0 that cycle; next state is IDLE and gnt_o clears. This gives one dead cycle between owners.
  - Requests from other masters are ignored until IDLE; no preemption.
- Watchdog (TIMEOUT>0):
  - The counter increments each OWN cycle with s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, on err, or when stb is low.
  - When the count equals TIMEOUT, the next state is TERR.
- TERR (1 cycle):
  - s_cyc_o=s_stb_o=0; m_err_o[g]=1; the counter clears.
  - Next state is OWN if m_cyc_i[g] is still high, else IDLE.
  - A late s_ack_i or s_err_i arriving in TERR is not forwarded.
- Simultaneous events:
  - If ack and timeout coincide, ack wins and the counter clears.
  - If cyc drops while the counter is nonzero, go to IDLE with no error.
- Ack and err are never asserted to a non-granted master. gnt_o is always one-hot or zero.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum arb_state_e {ARB_IDLE, ARB_OWN, ARB_TERR};
  - a localparam function for the index width, clog2(NUM_MASTERS).
- Sub-module wb_rr_pick: combinational rotate-priority-pick. Inputs are the req vector and last_grant index; outputs are the one-hot winner and its index. It is reused by the planned interrupt arbiter.
- The watchdog counter is inline, with width clog2(TIMEOUT+1).

Test Plan:
- Single master 2 writes 0xA5 to 0x9000_0004:
  - gnt_o=0100 one cycle after cyc;
  - s_adr_o=0x9000_0004, s_dat_o=0xA5;
  - m_ack_o=0100 on s_ack_i;
  - busy_o falls the cycle after cyc drops.
- Masters 0,1,3 request simultaneously and continuously, each doing one-beat cycles:
  - grant order 0,1,3,0,1,3;
  - one dead IDLE cycle between grants.
- Master 1 holds cyc across 4 stb/ack beats while master 0 requests:
  - master 0 is not granted until master 1 drops cyc;
  - then gnt_o=0001.
- TIMEOUT=8, slave never acks:
  - m_err_o[g] pulses for exactly 1 cycle after 8 stalled stb cycles;
  - s_cyc_o=0 during that cycle;
  - if master g drops cyc, the arbiter returns to IDLE.
- rst_i asserted mid-read of master 3, then released:
  - all outputs 0 the cycle after reset;
  - with masters 0 and 3 both requesting, master 0 is granted first.
- Slave asserts s_err_i on a read:
  - only the granted master sees m_err_o;
  - other masters' ack and err stay 0;
  - the watchdog counter clears.
